// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the M-stage load/store controller and a
// multi-cycle, ack-based data memory.
interface mem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    // Controller side: issues the request, receives the ack and the read data
    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_be,
        input  mem_ack,
        input  mem_rdata
    );

    // Memory side
    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store controller. Runs one request/ack transaction per
// M-stage load or store, stalls the pipeline while it is outstanding, handles
// byte lanes, rejects misaligned word accesses and aborts on an ack timeout.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic              ByteM,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       WriteDataM,
    output logic [31:0]       ReadDataM,
    output logic              StallMem,
    output logic              MemErr,
    mem_access_unit_if.master mem
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [1:0]  lane_q, lane_d;
    logic        byte_q, byte_d;
    logic        load_q, load_d;

    logic        cmd;
    logic        misaligned;
    logic [7:0]  lane_byte;
    logic [31:0] load_result;

    assign cmd        = MemReadM | MemWriteM;
    assign misaligned = ~ByteM & (ALUResultM[1:0] != 2'b00);

    // Pick the addressed byte lane of the returned word for byte loads
    always_comb begin
        lane_byte = mem.mem_rdata[7:0];
        case (lane_q)
            2'd0:    lane_byte = mem.mem_rdata[7:0];
            2'd1:    lane_byte = mem.mem_rdata[15:8];
            2'd2:    lane_byte = mem.mem_rdata[23:16];
            default: lane_byte = mem.mem_rdata[31:24];
        endcase
        load_result = byte_q ? {24'h0, lane_byte} : mem.mem_rdata;
    end

    // Stall while a transaction is outstanding, including the IDLE cycle that launches it
    always_comb begin
        StallMem = 1'b0;
        if (reset) begin
            StallMem = (state_q == BUSY) ||
                       ((state_q == IDLE) && cmd && !misaligned);
        end
    end

    // Next-state and register-update logic for the transaction FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        lane_d  = lane_q;
        byte_d  = byte_q;
        load_d  = load_q;

        case (state_q)
            IDLE: begin
                if (cmd) begin
                    if (misaligned) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = MemWriteM;
                        addr_d  = {ALUResultM[31:2], 2'b00};
                        wdata_d = ByteM ? {4{WriteDataM[7:0]}} : WriteDataM;
                        be_d    = ByteM ? (4'b0001 << ALUResultM[1:0]) : 4'hF;
                        lane_d  = ALUResultM[1:0];
                        byte_d  = ByteM;
                        load_d  = ~MemWriteM;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (mem.mem_ack) begin
                    req_d = 1'b0;
                    if (load_q) begin
                        rdata_d = load_result;
                    end
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            lane_q  <= '0;
            byte_q  <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            lane_q  <= lane_d;
            byte_q  <= byte_d;
            load_q  <= load_d;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_be    = be_q;
    assign ReadDataM     = rdata_q;
    assign MemErr        = err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, hand-written
// multi-cycle sequences, and randomized transactions against a word-memory model.
module tb_mem_access_unit;
    localparam int unsigned TO = 8;

    logic        clk;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic        ByteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallMem;
    logic        MemErr;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ByteM      (ByteM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallMem   (StallMem),
        .MemErr     (MemErr),
        .mem        (bus.master)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic        byt;
        logic [31:0] addr;
        logic [31:0] wd;
        int unsigned lat;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic        e_we;
        logic [31:0] e_rd;
    } vec_t;

    vec_t        tbl [8];
    int          n_cmp = 0;
    int          n_mis = 0;
    int          req_edges = 0;
    logic        req_prev = 1'b0;
    logic [31:0] m_rd;
    logic        m_err;
    logic [31:0] mem_model [bit [31:0]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count request transactions (rising edges of mem_req)
    always @(negedge clk) begin
        if (bus.mem_req === 1'b1 && req_prev !== 1'b1) req_edges++;
        req_prev = bus.mem_req;
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        ByteM      = 1'b0;
        ALUResultM = '0;
        WriteDataM = '0;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] wa);
        if (mem_model.exists(wa)) return mem_model[wa];
        return wa * 32'h9E3779B1 + 32'h1234;
    endfunction

    // One complete M-stage instruction: launch, BUSY cycles, DONE, back to IDLE
    task automatic do_op(input logic rd, input logic wr, input logic byt,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int unsigned lat, input logic [31:0] rdata,
                         input logic [31:0] e_addr, input logic [3:0] e_be,
                         input logic [31:0] e_wd, input logic e_we,
                         input logic [31:0] e_rd);
        logic        misal;
        int unsigned last;
        logic [31:0] wa;
        logic [4:0]  sh;
        MemReadM   = rd;
        MemWriteM  = wr;
        ByteM      = byt;
        ALUResultM = addr;
        WriteDataM = wd;
        bus.mem_ack = 1'b0;
        #1;
        misal = !byt && (addr[1:0] != 2'b00);
        if (misal) begin
            chk1("misal_nostall", StallMem, 1'b0);
            tick();
            m_err = 1'b1;
            m_rd  = '0;
            chk1("misal_noreq", bus.mem_req, 1'b0);
            chk1("misal_err", MemErr, m_err);
            chk32("misal_rd", ReadDataM, m_rd);
            idle_inputs();
            return;
        end
        chk1("launch_stall", StallMem, 1'b1);
        last = (lat == 0) ? TO : lat;
        for (int unsigned c = 1; c <= last; c++) begin
            tick();
            bus.mem_ack = 1'b0;
            chk1("busy_stall", StallMem, 1'b1);
            chk1("busy_req", bus.mem_req, 1'b1);
            chk32("busy_addr", bus.mem_addr, e_addr);
            chk32("busy_be", {28'h0, bus.mem_be}, {28'h0, e_be});
            chk32("busy_wdata", bus.mem_wdata, e_wd);
            chk1("busy_we", bus.mem_we, e_we);
            if (c == lat) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rdata;
            end else begin
                bus.mem_rdata = $urandom;
            end
        end
        tick();
        // a stray ack in DONE must be ignored
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        if (lat == 0) begin
            m_rd  = '0;
            m_err = 1'b1;
        end else if (!wr) begin
            m_rd = e_rd;
        end else begin
            wa = addr & ~32'h3;
            sh = {addr[1:0], 3'b000};
            if (byt) mem_model[wa] = (mem_word(wa) & ~(32'hFF << sh)) | ({24'h0, wd[7:0]} << sh);
            else     mem_model[wa] = wd;
        end
        chk1("done_stall", StallMem, 1'b0);
        chk1("done_req", bus.mem_req, 1'b0);
        chk32("done_rd", ReadDataM, m_rd);
        chk1("done_err", MemErr, m_err);
        tick();
        bus.mem_ack = 1'b0;
        idle_inputs();
        #1;
        chk1("idle_stall", StallMem, 1'b0);
        chk1("idle_req", bus.mem_req, 1'b0);
        chk32("idle_rd", ReadDataM, m_rd);
    endtask

    task automatic rand_op();
        logic        rd, wr, byt;
        logic [31:0] addr, wd, wa, rdata, e_rd;
        logic [1:0]  lane;
        logic [3:0]  e_be;
        int unsigned kind, lat, low;
        kind = $urandom_range(0, 3);
        rd   = (kind != 2);
        wr   = (kind >= 2);
        byt  = 1'($urandom_range(0, 1));
        if (byt) low = $urandom_range(0, 3);
        else     low = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
        addr = 32'h400 + 32'(4 * $urandom_range(0, 7)) + 32'(low);
        wd   = $urandom;
        lat  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
        lane = addr[1:0];
        wa   = addr & ~32'h3;
        rdata = wr ? $urandom : mem_word(wa);
        e_rd  = byt ? ((rdata >> (8 * lane)) & 32'hFF) : rdata;
        e_be  = byt ? 4'(1 << lane) : 4'hF;
        do_op(rd, wr, byt, addr, wd, lat, rdata, wa, e_be,
              byt ? ({24'h0, wd[7:0]} * 32'h01010101) : wd, wr, e_rd);
    endtask

    initial begin
        int e0;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h100,  32'h0,        3, 32'hDEADBEEF, 32'h100,  4'hF,    32'h0,        1'b0, 32'hDEADBEEF};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h1003, 32'h123456AB, 1, 32'h0,        32'h1000, 4'b1000, 32'hABABABAB, 1'b1, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 32'h1002, 32'h55,       2, 32'h11223344, 32'h1000, 4'b0100, 32'h55555555, 1'b0, 32'h22};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 32'h2001, 32'h0,        1, 32'hA1B2C3D4, 32'h2000, 4'b0010, 32'h0,        1'b0, 32'hC3};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h300,  32'hCAFEF00D, 1, 32'hFFFFFFFF, 32'h300,  4'hF,    32'hCAFEF00D, 1'b1, 32'h0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h40,   32'h01020304, 4, 32'h0,        32'h40,   4'hF,    32'h01020304, 1'b1, 32'h0};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 32'h3000, 32'h0,        1, 32'h000000F0, 32'h3000, 4'b0001, 32'h0,        1'b0, 32'hF0};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 32'h3003, 32'h0,        1, 32'h80000000, 32'h3000, 4'b1000, 32'h0,        1'b0, 32'h80};

        // Reset with a command present: everything zero, no stall
        reset = 1'b0;
        MemReadM = 1'b1; MemWriteM = 1'b0; ByteM = 1'b0;
        ALUResultM = 32'h100; WriteDataM = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        m_rd = '0; m_err = 1'b0;
        #12;
        chk1("rst_stall", StallMem, 1'b0);
        chk1("rst_req", bus.mem_req, 1'b0);
        chk1("rst_we", bus.mem_we, 1'b0);
        chk32("rst_be", {28'h0, bus.mem_be}, 32'h0);
        chk32("rst_addr", bus.mem_addr, 32'h0);
        chk32("rst_wdata", bus.mem_wdata, 32'h0);
        chk32("rst_rd", ReadDataM, 32'h0);
        chk1("rst_err", MemErr, 1'b0);
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].rd, tbl[i].wr, tbl[i].byt, tbl[i].addr, tbl[i].wd, tbl[i].lat,
                  tbl[i].rdata, tbl[i].e_addr, tbl[i].e_be, tbl[i].e_wd, tbl[i].e_we, tbl[i].e_rd);
        end

        // Misaligned word load: no request, sticky error
        e0 = req_edges;
        do_op(1'b1, 1'b0, 1'b0, 32'h1002, 32'h0, 1, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        chk1("err_sticky", MemErr, 1'b1);
        chk32("misal_req_count", 32'(req_edges - e0), 32'h0);

        // Timeout abort, then an ack on the very last allowed BUSY cycle still completes
        do_op(1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 0, 32'h0, 32'h600, 4'hF, 32'h0, 1'b0, 32'h0);
        do_op(1'b1, 1'b0, 1'b0, 32'h604, 32'h0, TO, 32'h5A5A1234, 32'h604, 4'hF, 32'h0, 1'b0, 32'h5A5A1234);

        // Reset in the middle of BUSY, with an ack arriving afterwards
        MemReadM = 1'b1; ALUResultM = 32'h500; ByteM = 1'b0; MemWriteM = 1'b0;
        #1;
        chk1("rb_launch_stall", StallMem, 1'b1);
        tick();
        tick();
        chk1("rb_busy_req", bus.mem_req, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk1("rb_req", bus.mem_req, 1'b0);
        chk1("rb_stall", StallMem, 1'b0);
        chk32("rb_addr", bus.mem_addr, 32'h0);
        chk32("rb_be", {28'h0, bus.mem_be}, 32'h0);
        chk32("rb_rd", ReadDataM, 32'h0);
        chk1("rb_err", MemErr, 1'b0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0BAD0;
        tick();
        bus.mem_ack = 1'b0;
        idle_inputs();
        #2 reset = 1'b1;
        tick();
        chk1("rb_post_req", bus.mem_req, 1'b0);
        chk1("rb_post_stall", StallMem, 1'b0);
        chk32("rb_post_rd", ReadDataM, 32'h0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD1BAD1;
        tick();
        bus.mem_ack = 1'b0;
        chk32("idle_ack_ignored", ReadDataM, 32'h0);
        chk1("idle_ack_noreq", bus.mem_req, 1'b0);
        m_rd = '0; m_err = 1'b0;

        // Back-to-back store then load of the same word
        e0 = req_edges;
        do_op(1'b0, 1'b1, 1'b0, 32'h20, 32'h89ABCDEF, 1, 32'h0, 32'h20, 4'hF, 32'h89ABCDEF, 1'b1, 32'h0);
        do_op(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 1, mem_word(32'h20), 32'h20, 4'hF, 32'h0, 1'b0, 32'h89ABCDEF);
        chk32("b2b_req_count", 32'(req_edges - e0), 32'h2);

        // Randomized transactions against the memory model
        for (int i = 0; i < 60; i++) rand_op();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
